// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS core control blocks.
package mips_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard-sequencer bundle: hazard inputs from the pipeline, stage controls and status back.
interface hazard_ctrl_if #(parameter int REG_W = 5);

    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             ex_mem_read;
    logic [REG_W-1:0] ex_rt;
    logic             branch_taken;
    logic             mem_busy;
    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             ex_mem_hold;
    logic             timeout;
    logic [31:0]      stall_cycles;
    logic [15:0]      flush_count;

    modport master (
        output id_rs, id_rt, ex_mem_read, ex_rt, branch_taken, mem_busy,
        input  pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_hold,
        input  timeout, stall_cycles, flush_count
    );

    modport slave (
        input  id_rs, id_rt, ex_mem_read, ex_rt, branch_taken, mem_busy,
        output pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_hold,
        output timeout, stall_cycles, flush_count
    );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear has priority over enable.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: load-use stalls, branch flushes, data-memory freeze with watchdog.
module hazard_ctrl
    import mips_pkg::*;
#(
    parameter int MAX_WAIT = 8,
    parameter int REG_W    = 5
) (
    input logic         clk,
    input logic         rst,
    hazard_ctrl_if.slave hz
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   wait_q, wait_d, wait_inc;
    logic               timeout_q, timeout_d;
    logic               lu, freeze;
    logic               pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_hold;
    logic               branch_flush;

    assign lu = hz.ex_mem_read && (hz.ex_rt != REG_W'(REG_ZERO)) &&
                ((hz.ex_rt == hz.id_rs) || (hz.ex_rt == hz.id_rt));

    assign wait_inc = wait_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        timeout_d    = timeout_q;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        ex_mem_hold  = 1'b0;
        branch_flush = 1'b0;

        // HALT freezes unconditionally; otherwise a busy memory freezes and hides branch/lu
        freeze = (state_q == HALT) || hz.mem_busy;

        if (rst) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            state_d      = RUN;
            wait_d       = '0;
            timeout_d    = 1'b0;
        end else begin
            if (freeze) begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                ex_mem_hold = 1'b1;
            end else if (hz.branch_taken) begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
                branch_flush = 1'b1;
            end else if (lu) begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
            end

            unique case (state_q)
                RUN: begin
                    if (hz.mem_busy) begin
                        state_d = MEM_WAIT;
                        wait_d  = CNT_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (hz.mem_busy) begin
                        wait_d = wait_inc;
                        if (wait_inc == CNT_W'(MAX_WAIT)) begin
                            timeout_d = 1'b1;
                            state_d   = HALT;
                        end
                    end else begin
                        state_d = RUN;
                        wait_d  = '0;
                    end
                end
                HALT: ;
                default: state_d = RUN;
            endcase
        end
    end

    sat_counter #(.W(32)) u_stall_cnt (
        .clk (clk),
        .clr (rst),
        .en  (!rst && !pc_write),
        .cnt (hz.stall_cycles)
    );

    sat_counter #(.W(16)) u_flush_cnt (
        .clk (clk),
        .clr (rst),
        .en  (!rst && branch_flush),
        .cnt (hz.flush_count)
    );

    assign hz.pc_write     = pc_write;
    assign hz.if_id_write  = if_id_write;
    assign hz.if_id_flush  = if_id_flush;
    assign hz.id_ex_bubble = id_ex_bubble;
    assign hz.ex_mem_hold  = ex_mem_hold;
    assign hz.timeout      = timeout_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios with literal checks plus randomized traffic vs a behavioural model.
module tb_hazard_ctrl;

    localparam int MAX_WAIT = 8;
    localparam int REG_W    = 5;

    logic clk;
    logic rst;

    hazard_ctrl_if #(.REG_W(REG_W)) hif ();

    hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .REG_W(REG_W)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model: consecutive busy cycles seen, halted flag, counter values
    int     m_busy_run = 0;
    bit     m_halted   = 0;
    longint m_stall    = 0;
    longint m_flush    = 0;
    bit     e_pw, e_iw, e_fl, e_bb, e_hd;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic bit is_lu();
        return hif.ex_mem_read && (hif.ex_rt != 0) &&
               (hif.ex_rt == hif.id_rs || hif.ex_rt == hif.id_rt);
    endfunction

    // Compare process: expectations from the rules, applied mid-cycle
    always @(negedge clk) begin
        if (rst)                               {e_pw, e_iw, e_fl, e_bb, e_hd} = 5'b00110;
        else if (m_halted || hif.mem_busy)     {e_pw, e_iw, e_fl, e_bb, e_hd} = 5'b00001;
        else if (hif.branch_taken)             {e_pw, e_iw, e_fl, e_bb, e_hd} = 5'b11110;
        else if (is_lu())                      {e_pw, e_iw, e_fl, e_bb, e_hd} = 5'b00010;
        else                                   {e_pw, e_iw, e_fl, e_bb, e_hd} = 5'b11000;
        chk("pc_write",     64'(hif.pc_write),     64'(e_pw));
        chk("if_id_write",  64'(hif.if_id_write),  64'(e_iw));
        chk("if_id_flush",  64'(hif.if_id_flush),  64'(e_fl));
        chk("id_ex_bubble", 64'(hif.id_ex_bubble), 64'(e_bb));
        chk("ex_mem_hold",  64'(hif.ex_mem_hold),  64'(e_hd));
        chk("timeout",      64'(hif.timeout),      64'(m_halted));
        chk("stall_cycles", 64'(hif.stall_cycles), 64'(m_stall));
        chk("flush_count",  64'(hif.flush_count),  64'(m_flush));
    end

    always @(posedge clk) begin
        if (rst) begin
            m_busy_run = 0;
            m_halted   = 0;
            m_stall    = 0;
            m_flush    = 0;
        end else begin
            if (!e_pw && m_stall < 64'hFFFF_FFFF) m_stall++;
            if (e_fl && m_flush < 64'hFFFF)       m_flush++;
            if (!m_halted) begin
                if (hif.mem_busy) begin
                    m_busy_run++;
                    if (m_busy_run == MAX_WAIT) m_halted = 1;
                end else begin
                    m_busy_run = 0;
                end
            end
        end
    end

    // Drive inputs just after the edge, leaving a short settle before literal checks
    task automatic set_in(input bit r, input int rs, input int rt, input bit mr,
                          input int ert, input bit br, input bit busy);
        rst              = r;
        hif.id_rs        = REG_W'(rs);
        hif.id_rt        = REG_W'(rt);
        hif.ex_mem_read  = mr;
        hif.ex_rt        = REG_W'(ert);
        hif.branch_taken = br;
        hif.mem_busy     = busy;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            set_in(0, 1, 2, 0, 0, 0, 0);
            tick();
        end
    endtask

    task automatic do_reset();
        set_in(1, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    int burst;
    bit r_rst, r_br, r_mr;

    initial begin
        set_in(1, 0, 0, 0, 0, 0, 0);
        tick();
        chk("rst_pc_write", 64'(hif.pc_write), 64'd0);
        chk("rst_flush",    64'(hif.if_id_flush), 64'd1);
        tick();
        idle(1);
        chk("post_rst_stall",   64'(hif.stall_cycles), 64'd0);
        chk("post_rst_timeout", 64'(hif.timeout), 64'd0);

        // Load-use stall, then the same with $zero as destination
        set_in(0, 5, 7, 1, 5, 0, 0);
        chk("lu_pc_write", 64'(hif.pc_write), 64'd0);
        chk("lu_bubble",   64'(hif.id_ex_bubble), 64'd1);
        tick();
        chk("lu_stall_cnt", 64'(hif.stall_cycles), 64'd1);
        set_in(0, 0, 7, 1, 0, 0, 0);
        chk("zero_pc_write", 64'(hif.pc_write), 64'd1);
        tick();
        chk("zero_stall_cnt", 64'(hif.stall_cycles), 64'd1);

        // Branch flush, then branch beating a simultaneous load-use
        set_in(0, 1, 2, 0, 0, 1, 0);
        chk("br_flush", 64'(hif.if_id_flush), 64'd1);
        tick();
        chk("br_flush_cnt", 64'(hif.flush_count), 64'd1);
        set_in(0, 3, 9, 1, 9, 1, 0);
        chk("br_lu_pc_write", 64'(hif.pc_write), 64'd1);
        tick();
        chk("br_lu_flush_cnt", 64'(hif.flush_count), 64'd2);
        chk("br_lu_stall_cnt", 64'(hif.stall_cycles), 64'd1);

        // Three busy cycles then release
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(0, 1, 2, 0, 0, 0, 1);
            chk("busy_hold", 64'(hif.ex_mem_hold), 64'd1);
            tick();
        end
        set_in(0, 1, 2, 0, 0, 0, 0);
        chk("release_pc_write", 64'(hif.pc_write), 64'd1);
        chk("release_hold",     64'(hif.ex_mem_hold), 64'd0);
        tick();
        chk("busy3_stall_cnt", 64'(hif.stall_cycles), 64'd3);

        // Watchdog: MAX_WAIT busy cycles halt the pipeline until reset
        do_reset();
        for (int i = 0; i < MAX_WAIT; i++) begin
            set_in(0, 1, 2, 0, 0, 0, 1);
            tick();
        end
        set_in(0, 1, 2, 0, 0, 1, 0);
        chk("halt_timeout",  64'(hif.timeout), 64'd1);
        chk("halt_pc_write", 64'(hif.pc_write), 64'd0);
        tick();
        chk("halt_stall_cnt", 64'(hif.stall_cycles), 64'd9);
        do_reset();
        set_in(0, 1, 2, 0, 0, 0, 0);
        chk("halt_cleared", 64'(hif.timeout), 64'd0);
        tick();

        // Reset arriving mid-freeze with a branch pending
        set_in(0, 1, 2, 0, 0, 0, 1);
        tick();
        set_in(1, 1, 2, 0, 0, 1, 1);
        chk("rst_mw_flush",  64'(hif.if_id_flush), 64'd1);
        chk("rst_mw_bubble", 64'(hif.id_ex_bubble), 64'd1);
        tick();
        set_in(0, 1, 2, 0, 0, 0, 0);
        chk("rst_mw_stall_cnt", 64'(hif.stall_cycles), 64'd0);
        chk("rst_mw_run",       64'(hif.pc_write), 64'd1);
        tick();

        // Randomized traffic
        burst = 0;
        for (int i = 0; i < 4000; i++) begin
            r_rst = ($urandom_range(0, 79) == 0);
            if (burst == 0 && $urandom_range(0, 7) == 0) burst = int'($urandom_range(1, 11));
            r_br = ($urandom_range(0, 5) == 0);
            r_mr = ($urandom_range(0, 1) == 1);
            set_in(r_rst, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), r_mr,
                   int'($urandom_range(0, 3)), r_br, burst > 0);
            if (burst > 0) burst--;
            tick();
        end

        set_in(0, 1, 2, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
